// File: rtl/pdm_capture_seq_if.sv
// Memory write port between the capture sequencer and its memory/bus side.
//
// Handshake: wr_en is the valid; wr_ready is the ready. A word moves on every
// clock edge where wr_en & wr_ready. Once wr_en is high, wr_addr/wr_data are
// held stable and wr_en stays high until that edge. Exception: an abort
// withdraws a pending word. wr_ready may be driven freely and may depend on
// wr_en.
//
// Signals:
//   wr_en     master -> slave  write request (FIFO non-empty)
//   wr_addr   master -> slave  32-bit byte address of the word
//   wr_data   master -> slave  32-bit captured PDM word
//   wr_ready  slave -> master  write accept
interface pdm_capture_seq_if;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pdm_capture_seq.sv
// Capture sequencer for the pdm_m PDM datapath (AHBclk domain).
// A start command with a base address and a word count steps pdm_m through
// arm (ctrl 10), run (ctrl 01) and idle (ctrl 00). Each completed word is
// flagged by a falling edge of pdm_bsy. The word is queued with its address
// in a 2-entry FIFO, and the FIFO drains to the memory write port.
//
// Ports:
//   AHBclk       clock
//   rst          asynchronous reset, active-low
//   start        1-cycle command pulse, honoured only in IDLE
//   abort        level, cancels an active capture (ARM/RUN/DRAIN)
//   base_addr    address of word 0, sampled on an accepted start
//   num_words    number of words, sampled on an accepted start
//   pdm_ctrl     pdm_m control: 00 idle, 10 arm, 01 run
//   pdm_addr     address of the word currently being captured
//   pdm_dout     pdm_m output word
//   pdm_bsy      pdm_m busy; a 1->0 edge means a word is ready
//   wr           write port (master side)
//   busy         high in every state except IDLE
//   done         1-cycle completion pulse
//   overflow     sticky, set when a word is dropped on a full FIFO
//   timeout_err  sticky, set when no word completes within TIMEOUT run cycles
//   words_done   completed write transfers, saturating
//   state_dbg    current FSM state encoding
module pdm_capture_seq #(
  parameter int ARM_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  parameter int ADDR_STEP  = 4
) (
  input  logic                     AHBclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [31:0]              base_addr,
  input  logic [15:0]              num_words,
  output logic [1:0]               pdm_ctrl,
  output logic [31:0]              pdm_addr,
  input  logic [31:0]              pdm_dout,
  input  logic                     pdm_bsy,
  pdm_capture_seq_if.master        wr,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic                     timeout_err,
  output logic [15:0]              words_done,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, next_state;
  logic          bsy_q;
  logic [AW-1:0] arm_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   num_q;
  logic [15:0]   idx;
  logic [31:0]   addr_q;

  logic [63:0]   fifo_mem [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count;

  logic fall, pop, push, full, start_ok, abort_ok, tmo_hit;

  assign state_dbg  = state;
  assign pdm_addr   = addr_q;
  assign full       = (count == 2'd2);
  assign wr.wr_en   = (count != 2'd0);
  assign wr.wr_addr = fifo_mem[rd_ptr][63:32];
  assign wr.wr_data = fifo_mem[rd_ptr][31:0];

  always_comb begin
    next_state = state;
    pdm_ctrl   = 2'b00;
    busy       = 1'b1;
    done       = 1'b0;
    start_ok   = 1'b0;
    abort_ok   = 1'b0;
    tmo_hit    = 1'b0;
    fall       = (state == S_RUN) && bsy_q && !pdm_bsy;
    pop        = wr.wr_en && wr.wr_ready;
    // A full FIFO still accepts a word if the head leaves in the same cycle.
    push       = fall && (!full || pop);
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_ok   = 1'b1;
          next_state = (num_words != 16'd0) ? S_ARM : S_DONE;
        end
      end
      S_ARM: begin
        pdm_ctrl = 2'b10;
        if (arm_cnt == ARM_LAST) next_state = S_RUN;
      end
      S_RUN: begin
        pdm_ctrl = 2'b01;
        if (fall && (idx + 16'd1 == num_q)) begin
          next_state = S_DRAIN;
        end else if (!fall && (tmo_cnt == TMO_LAST)) begin
          tmo_hit    = 1'b1;
          next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count == 2'd0) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    if (abort && (state == S_ARM || state == S_RUN || state == S_DRAIN)) begin
      abort_ok   = 1'b1;
      next_state = S_IDLE;
    end
  end

  always_ff @(posedge AHBclk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      bsy_q       <= 1'b0;
      arm_cnt     <= '0;
      tmo_cnt     <= '0;
      num_q       <= '0;
      idx         <= '0;
      addr_q      <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      words_done  <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
    end else begin
      state <= next_state;
      bsy_q <= pdm_bsy;
      arm_cnt <= (state == S_ARM) ? arm_cnt + 1'b1 : '0;
      // Only non-RUN cycles and word completions restart the watchdog.
      tmo_cnt <= (state == S_RUN && !fall) ? tmo_cnt + 1'b1 : '0;

      if (start_ok) begin
        num_q       <= num_words;
        idx         <= '0;
        addr_q      <= base_addr;
        overflow    <= 1'b0;
        timeout_err <= 1'b0;
        words_done  <= '0;
      end else begin
        // A dropped word still advances the index and address.
        if (fall) begin
          idx    <= idx + 16'd1;
          addr_q <= addr_q + 32'(ADDR_STEP);
          if (full && !pop) overflow <= 1'b1;
        end
        if (tmo_hit) timeout_err <= 1'b1;
        // A transfer on the abort edge still counts.
        if (pop && words_done != 16'hFFFF) words_done <= words_done + 16'd1;
      end

      if (abort_ok) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= {addr_q, pdm_dout};
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
